// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the register write sequencer.
package reg_wr_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_DCNT_LO = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DCNT_HI = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_VDD     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/reg_wr_arb_rr_arb2.sv
// Two-way arbiter producing a one-hot grant.
// REG_WR_ARB_RR_EN selects round-robin tie-breaking; otherwise requester 0 wins ties.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       first_tie,
    input  logic       en,
    output logic [1:0] gnt
);

`ifndef REG_WR_ARB_RR_EN
    logic unused_rr;
    assign unused_rr = last ^ first_tie;
`endif

    // One-hot grant among the valid requesters, zero when disabled
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
`ifdef REG_WR_ARB_RR_EN
                gnt = (first_tie || last) ? 2'b01 : 2'b10;
`else
                gnt = 2'b01;
`endif
            end else begin
                gnt = valid;
            end
        end
    end

endmodule

// File: rtl/reg_wr_arb.sv
// Bus-write sequencer/arbiter for the divider/level register block.
// Optional build macro REG_WR_ARB_RR_EN enables round-robin arbitration.
module reg_wr_arb
    import reg_wr_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rd,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] db_o,
    output logic              db_oe,
    output logic              wr,
    output logic              busy,
    output logic              gnt_id,
    output logic              conflict
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rdy_en;
    logic             tie_seen;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             tie;
    wr_req_t          win;

    assign arb_en = (state == ST_IDLE) && rd && rdy_en;
    assign tie    = req0_valid && req1_valid;

    rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .last      (gnt_id),
        .first_tie (!tie_seen),
        .en        (arb_en),
        .gnt       (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Payload of the winning requester
    always_comb begin
        win = gnt[1] ? wr_req_t'{addr: req1_addr, data: req1_data}
                     : wr_req_t'{addr: req0_addr, data: req0_data};
    end

    // Write-cycle sequencer with registered bus outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rdy_en   <= 1'b0;
            tie_seen <= 1'b0;
            a        <= '0;
            db_o     <= '0;
            db_oe    <= 1'b0;
            wr       <= 1'b0;
            busy     <= 1'b0;
            gnt_id   <= 1'b0;
            conflict <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (!rd && db_oe) begin
                conflict <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        a      <= win.addr;
                        db_o   <= win.data;
                        gnt_id <= gnt[1];
                        db_oe  <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= SETUP_LD;
                        state  <= ST_SETUP;
                        if (tie) begin
                            tie_seen <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        wr    <= 1'b1;
                        cnt   <= STROBE_LD;
                        state <= ST_STROBE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt == '0) begin
                        wr    <= 1'b0;
                        cnt   <= HOLD_LD;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        db_oe <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wr_arb.sv
// Self-checking bench for reg_wr_arb: randomized requesters and rd against a
// transaction-timeline reference model.
module tb_reg_wr_arb;
    import reg_wr_pkg::*;

    localparam int S   = 2;
    localparam int ST  = 2;
    localparam int H   = 1;
    localparam int TOT = S + ST + H;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, rd;
    logic [2:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [2:0]  a;
    logic [15:0] db_o;
    logic        db_oe, wr, busy, gnt_id, conflict;

    reg_wr_arb #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rd         (rd),
        .a          (a),
        .db_o       (db_o),
        .db_oe      (db_oe),
        .wr         (wr),
        .busy       (busy),
        .gnt_id     (gnt_id),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    // Register block: latches on the rising edge of wr
    logic [15:0] obs_reg [8];
    always @(posedge wr) obs_reg[a] = db_o;

    int n_chk = 0;
    int n_err = 0;

    // Model state: timeline of the last acceptance plus expected outputs
    int          k;
    int          last_acc;
    logic [2:0]  ea;
    logic [15:0] ed;
    logic        eg, ec, tie_m;
    logic [15:0] exp_reg [8];
    logic        pend [2];
    logic [2:0]  paddr [2];
    logic [15:0] pdata [2];
    logic        gen_en;
    int          rd_mode;
    int          acc_j;
    logic        acc_tie;
    logic        prev_rd, prev_oe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        last_acc = -1000;
        ea = '0; ed = '0; eg = 1'b0; ec = 1'b0; tie_m = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        acc_j = -1; acc_tie = 1'b0;
        prev_rd = 1'b1; prev_oe = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // One clock period: update model at the edge, drive inputs, check outputs
    task automatic cycle();
        logic idle, oe, wrx, has;
        int   sel;
        @(posedge clk);
        k++;
        if (acc_j >= 0) begin
            last_acc = k;
            ea = paddr[acc_j];
            ed = pdata[acc_j];
            eg = 1'(acc_j);
            pend[acc_j] = 1'b0;
            if (acc_tie) tie_m = 1'b1;
        end
        if (k == last_acc + S) exp_reg[ea] = ed;
        if (!prev_rd && prev_oe) ec = 1'b1;
        #1;
        for (int j = 0; j < 2; j++) begin
            if (gen_en) begin
                if (!pend[j] && ($urandom % 4 == 0)) begin
                    pend[j]  = 1'b1;
                    paddr[j] = 3'($urandom);
                    pdata[j] = 16'($urandom);
                end else if (pend[j] && ($urandom % 32 == 0)) begin
                    pend[j] = 1'b0;
                end
            end
        end
        idle = (k >= last_acc + TOT);
        case (rd_mode)
            0:       rd = 1'b1;
            1:       rd = 1'b0;
            2:       rd = idle ? 1'($urandom % 3 != 0) : 1'b1;
            default: rd = 1'($urandom % 4 != 0);
        endcase
        req0_valid = pend[0]; req0_addr = paddr[0]; req0_data = pdata[0];
        req1_valid = pend[1]; req1_addr = paddr[1]; req1_data = pdata[1];
        #1;
        oe  = (k >= last_acc) && (k < last_acc + TOT);
        wrx = (k >= last_acc + S) && (k < last_acc + S + ST);
        check("db_oe", 32'(db_oe), 32'(oe));
        check("busy", 32'(busy), 32'(oe));
        check("wr", 32'(wr), 32'(wrx));
        check("a", 32'(a), 32'(ea));
        check("db_o", 32'(db_o), 32'(ed));
        check("gnt_id", 32'(gnt_id), 32'(eg));
        check("conflict", 32'(conflict), 32'(ec));
        has = pend[0] || pend[1];
        if (pend[0] && pend[1]) begin
`ifdef REG_WR_ARB_RR_EN
            sel = (!tie_m || eg) ? 0 : 1;
`else
            sel = 0;
`endif
        end else begin
            sel = pend[0] ? 0 : 1;
        end
        check("req0_ready", 32'(req0_ready), 32'(idle && rd && has && sel == 0));
        check("req1_ready", 32'(req1_ready), 32'(idle && rd && has && sel == 1));
        acc_j   = (idle && rd && has) ? sel : -1;
        acc_tie = pend[0] && pend[1];
        prev_rd = rd;
        prev_oe = oe;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic post(input int j, input logic [2:0] ad, input logic [15:0] dt);
        pend[j] = 1'b1; paddr[j] = ad; pdata[j] = dt;
    endtask

    // Run until the model is in the strobe window; false if the budget expires
    task automatic wait_strobe(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            cycle();
            if (k == last_acc + S) ok = 1'b1;
        end
        if (!ok) check("wait_strobe", 32'd0, 32'd1);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) check(tag, 32'(obs_reg[i]), 32'(exp_reg[i]));
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < 8; i++) begin
            obs_reg[i] = '0;
            exp_reg[i] = '0;
        end
        k = 0;
        gen_en = 1'b0;
        rd_mode = 0;
        model_reset();
        paddr[0] = '0; paddr[1] = '0; pdata[0] = '0; pdata[1] = '0;
        rst = 1'b0;
        rd = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_addr = 3'd1; req1_addr = 3'd2;
        req0_data = 16'hffff; req1_data = 16'haaaa;

        // Reset state, including readys held low with both valids up
        #3;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_db_oe", 32'(db_oe), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_db_o", 32'(db_o), 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);
        check("rst_conflict", 32'(conflict), 32'd0);
        #19;
        check("rst_ready0_edge", 32'(req0_ready), 32'd0);
        model_reset();
        rst = 1'b1;

        // Single write to VDD
        post(0, ADDR_VDD, 16'h1234);
        run(9);
        check("vdd_reg", 32'(obs_reg[ADDR_VDD]), 32'h1234);

        // Tie between the two requesters
        post(0, ADDR_DCNT_LO, 16'h0ea5);
        post(1, ADDR_VDD, 16'h0800);
        run(15);

        // Back-to-back from each requester in turn
        post(1, ADDR_DCNT_HI, 16'h00c3);
        run(2);
        post(0, ADDR_COMMIT, 16'h0001);
        run(14);
        check_regs("regs_directed");

        // rd held low blocks the grant
        post(1, 3'd5, 16'hbeef);
        rd_mode = 1;
        run(5);
        rd_mode = 0;
        run(8);

        // rd pulsed low during strobe: conflict set, cycle completes
        post(0, 3'd6, 16'h5a5a);
        wait_strobe(ok);
        rd_mode = 1;
        cycle();
        rd_mode = 0;
        run(8);

        // Random traffic with rd low only while idle
        gen_en = 1'b1;
        rd_mode = 2;
        run(700);
        check_regs("regs_rand_idle");

        // Reset in the middle of a strobe
        rd_mode = 0;
        wait_strobe(ok);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_wr", 32'(wr), 32'd0);
        check("mid_rst_db_oe", 32'(db_oe), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_conflict", 32'(conflict), 32'd0);
        check("mid_rst_a", 32'(a), 32'd0);
        check("mid_rst_ready0", 32'(req0_ready), 32'd0);
        check("mid_rst_ready1", 32'(req1_ready), 32'd0);
        model_reset();
        @(posedge clk);
        k++;
        #2;
        rst = 1'b1;

        // Fully random traffic after reset, rd free-running
        rd_mode = 3;
        run(700);
        gen_en = 1'b0;
        rd_mode = 0;
        run(10);
        check_regs("regs_rand_full");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_wr_arb.md
# reg_wr_arb

Bus-write sequencer and arbiter for the divider/level register block. Two on-chip requesters (host configuration port and the level-ramp engine) submit register writes through valid/ready handshakes. The block grants one per slot and replays it as a timed write cycle on the shared 16-bit `DB` bus: address and data setup, a `wr` strobe whose rising edge is the register latch edge, then hold. It never drives `DB` while the register block is being read (`rd` low).

## Interface
- `SETUP_CYC`, 2: cycles `A`/`DB` are stable before `wr` rises; range 1–15.
- `STROBE_CYC`, 2: cycles `wr` stays high; range 1–15.
- `HOLD_CYC`, 1: cycles `A`/`DB` are held after `wr` falls; range 1–15.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: host write request; highest priority in fixed mode.
- `req0_addr` in 3: register address.
- `req0_data` in 16: write data.
- `req0_ready` out 1: acceptance strobe for requester 0.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for the ramp engine.
- `rd` in 1: register-block read strobe, active low. While low, the register block drives `DB`.
- `a` out 3: address to the register block.
- `db_o` out 16: write data.
- `db_oe` out 1: `DB` output enable.
- `wr` out 1: write strobe; the register block latches on its rising edge.
- `busy` out 1: high in any state other than IDLE.
- `gnt_id` out 1: requester owning the current or last cycle.
- `conflict` out 1: sticky flag, set when `rd` goes low while `db_oe` is high. Cleared only by reset.

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
- Phase counter: 4-bit, loaded with `N-1` on entry to each phase; the phase ends when the counter reaches 0.
- IDLE, granting:
  - A grant is possible only when `rd`=1 and at least one valid is high.
  - `reqN_ready` is combinational: high only in IDLE, with `rd`=1, for the selected requester.
  - The handshake completes at the clock edge where valid and ready are both high.
- At the accepting edge:
  - `a` and `db_o` are registered from the winning requester.
  - `gnt_id` is updated.
  - `db_oe` goes to 1 and the FSM moves to SETUP.
- SETUP: `wr`=0 for `SETUP_CYC` cycles.
- STROBE: `wr`=1 for `STROBE_CYC` cycles.
- HOLD: `wr`=0 and `db_oe`=1 for `HOLD_CYC` cycles. On the exit edge `db_oe` goes to 0 and the FSM returns to IDLE.
- `a` and `db_o` hold their last values in IDLE. They change only at acceptance.
- `rd` goes low mid-transaction: set `conflict` and complete the cycle unchanged. No abort, no retry.
- A request deasserted before it is accepted is dropped silently. Requesters must hold valid and payload until ready.
- Address 3 (commit) needs no special handling. Ordering of 0/1 before 3 is the requesters' responsibility.
- Reset values: FSM=IDLE, `wr`=0, `db_oe`=0, `a`=0, `db_o`=0, `busy`=0, `gnt_id`=0, `conflict`=0. Both readys are 0 until `rst` is released.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). The in-flight write is lost, and no `wr` edge is generated by the reset itself.

## Timing
- Acceptance at edge T0: `db_oe`=1 from T0.
- `wr` is high for cycles T0+SETUP_CYC through T0+SETUP_CYC+STROBE_CYC-1.
- Total transaction: SETUP_CYC+STROBE_CYC+HOLD_CYC cycles, plus at least 1 IDLE cycle before the next acceptance.
- Default back-to-back spacing: 6 cycles.
- All outputs are registered except the `reqN_ready` signals.

## Configuration
- `REG_WR_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the requester not in `gnt_id` wins.
  - The first tie after reset grants requester 0.
- `REG_WR_ARB_RR_EN` undefined: fixed priority; requester 0 always wins a tie.

## Structure
- Shared package `reg_wr_pkg` holds:
  - State enum (IDLE/SETUP/STROBE/HOLD).
  - Address constants: `ADDR_DCNT_LO`=0, `ADDR_DCNT_HI`=1, `ADDR_VDD`=2, `ADDR_COMMIT`=3.
  - Phase-counter width (4).
- One sub-module, `rr_arb2`: 2-way arbiter.
  - Inputs: valids, last grant, enable.
  - Outputs: one-hot grant.
  - Contains the `REG_WR_ARB_RR_EN` selection.

## Test plan
- Single write, defaults: `req0` addr 2, data 0x1234 →
  - `req0_ready` 1 for one cycle.
  - `db_oe` high 5 cycles; `wr` high in cycles 3–4 after acceptance.
  - Register VDD reads 0x1234.
- Tie, fixed mode: both valid together with addr 0/0x0EA5 and addr 2/0x0800 → requester 0 served first, requester 1 six cycles later.
- Tie, with `REG_WR_ARB_RR_EN`: both held valid for 4 transactions → `gnt_id` sequence 0,1,0,1.
- Read blocking: `rd` low while `req1_valid` is high →
  - `req1_ready` stays 0 and `db_oe` stays 0.
  - After `rd` goes high, the grant happens the next cycle.
- Conflict: `rd` pulsed low during STROBE → `conflict`=1 and stays 1; the transaction completes; `wr` pulse width is unchanged.
- Reset mid-STROBE: `rst` low → `wr`, `db_oe` and `busy` drop to 0 immediately. After release, a new request completes normally.
